te_resync_controller: RTL and testbench
=======================================

# te_resync_controller

Sequences the periodic resynchronisation of the trace encoder. It consumes the threshold flags from the resync counter and waits for the next qualified retirement. It then requests a synchronisation (format 3) packet from the packet emitter through a valid/ready handshake, and pulses the counter's reset once the request is accepted. It also keeps wait-time and resync-count status for debug.

## Interface
- `N`, default 2, number of retirement lanes (≥1)
- `MAX_WAIT`, default 16'd1024, wait cycles (ARMED+REQ) after which `timeout_o` is set
- `WAIT_W`, default 16, width of wait counter
- `LANE_W`, derived, `$clog2(N)` with minimum 1

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `trace_enabled_i`  in  1  tracing active, from filter
- `gt_resync_max_i`  in  1  counter above threshold
- `et_resync_max_i`  in  1  counter at threshold
- `valid_i`  in  N  qualified retirement per lane
- `sync_req_valid_o`  out  1  sync packet request
- `sync_req_lane_o`  out  LANE_W  lane the sync packet reports
- `sync_req_ready_i`  in  1  emitter accepts request
- `resync_rst_o`  out  1  one-cycle reset to resync counter
- `sync_pending_o`  out  1  resync owed, state ≠ IDLE
- `wait_cnt_o`  out  WAIT_W  cycles spent in current/last wait
- `timeout_o`  out  1  sticky: wait reached MAX_WAIT
- `clear_i`  in  1  clears `timeout_o`
- `resync_cnt_o`  out  16  completed resyncs, wraps

## Operation
- FSM states: IDLE, ARMED, REQ, RST. Registered state; all outputs are decoded from registers (no combinational path input→output).
- IDLE: `trigger = trace_enabled_i & (et_resync_max_i | gt_resync_max_i)`. On trigger → ARMED, and `wait_cnt` ← 0.
- ARMED:
  - If `trace_enabled_i`=0 → RST. The pending sync is dropped; enable restart produces its own sync.
  - Else if `valid_i`≠0: latch lowest set lane index → `sync_req_lane_o`, then → REQ.
  - Disable takes priority over a same-cycle retirement.
- REQ:
  - `sync_req_valid_o`=1, and the lane is held stable.
  - Valid is never withdrawn before handshake. `trace_enabled_i` is ignored here.
  - On `sync_req_ready_i`=1 → RST, and `resync_cnt` += 1 (mod 2^16).
- RST: `resync_rst_o`=1 for exactly this cycle → IDLE. Threshold flags are ignored in RST, because they are stale until the counter clears.
- `wait_cnt` increments each cycle in ARMED or REQ and saturates at 2^WAIT_W−1. It holds its value in RST/IDLE until the next trigger.
- `timeout_o` sets when `wait_cnt` = MAX_WAIT−1 while incrementing, i.e. on the MAX_WAIT-th wait cycle. It clears on `clear_i`; set wins over a simultaneous `clear_i`.
- `sync_pending_o` = (state ≠ IDLE).

## Timing
- Reset (`rst_i`=1 at edge) gives state IDLE. All outputs are 0, including `sync_req_lane_o`, `wait_cnt_o`, `timeout_o`, `resync_cnt_o`.
- Reset mid-operation abandons any request: `sync_req_valid_o` drops the next cycle with no handshake, and no `resync_rst_o` pulse is issued.
- Minimum latency:
  - trigger at cycle t → ARMED at t+1
  - retirement at t+1 → `sync_req_valid_o` at t+2
  - ready at t+2 → `resync_rst_o` at t+3
  - IDLE at t+4
  - A trigger is re-evaluated from t+4.
- Ready asserted while valid=0 has no effect.
- `wait_cnt_o` for the minimum path ends at 2: one ARMED cycle plus one REQ cycle.

## Test plan
- Basic: with enable=1, pulse `et_resync_max_i` at t0, `valid_i`=2'b10 at t0+1, ready=1 at t0+2. Expect `sync_req_valid_o` at t0+2 with lane=1; `resync_rst_o` only at t0+3; `resync_cnt_o`=1; `wait_cnt_o`=2; IDLE at t0+4.
- Backpressure: hold ready=0 for 5 cycles in REQ. Expect valid and lane stable throughout, and no `resync_rst_o` until the cycle after ready. Dropping enable during REQ must not abort the request.
- Disable while ARMED: trigger, then enable=0 together with `valid_i`=2'b11. Expect no request, `resync_rst_o` pulse on the next cycle, and `resync_cnt_o` unchanged.
- Timeout: with MAX_WAIT=4, trigger and keep `valid_i`=0. Expect `timeout_o`=1 from the cycle after the 4th wait cycle, and it stays 1 through IDLE. `clear_i` then clears it; `clear_i` coincident with a set keeps it 1.
- Stale flag: hold `gt_resync_max_i`=1 through the RST cycle, then deassert. Expect no second trigger.
- Reset mid-REQ: `rst_i` pulse while in REQ. Next cycle, all outputs are 0 and no `resync_rst_o` is issued.

Source files
------------

// File: rtl/te_resync_controller.sv
// te_resync_controller
// Sequences periodic resynchronisation of the trace encoder. The controller
// arms on a resync-counter threshold flag and waits for a qualified retirement.
// It then requests a format-3 sync packet over valid/ready and pulses the
// counter reset once that request is accepted. It also tracks the wait time,
// a sticky timeout flag and the number of completed resyncs for debug.
module te_resync_controller #(
  parameter int unsigned          N        = 2,
  parameter int unsigned          WAIT_W   = 16,
  parameter logic [WAIT_W-1:0]    MAX_WAIT = 16'd1024,
  localparam int unsigned         LANE_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trace_enabled_i,
  input  logic              gt_resync_max_i,
  input  logic              et_resync_max_i,
  input  logic [N-1:0]      valid_i,
  output logic              sync_req_valid_o,
  output logic [LANE_W-1:0] sync_req_lane_o,
  input  logic              sync_req_ready_i,
  output logic              resync_rst_o,
  output logic              sync_pending_o,
  output logic [WAIT_W-1:0] wait_cnt_o,
  output logic              timeout_o,
  input  logic              clear_i,
  output logic [15:0]       resync_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2,
    ST_RST   = 2'd3
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_SAT    = '1;
  localparam logic [WAIT_W-1:0] MAX_WAIT_M1 = MAX_WAIT - {{(WAIT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         resync_cnt_q, resync_cnt_d;

  logic                trigger_s;
  logic                in_wait_s;
  logic [LANE_W-1:0]   first_lane_s;

  assign trigger_s = trace_enabled_i & (et_resync_max_i | gt_resync_max_i);
  assign in_wait_s = (state_q == ST_ARMED) || (state_q == ST_REQ);

  // Lowest-index retiring lane; scanning downwards lets the lowest index win.
  always_comb begin
    first_lane_s = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        first_lane_s = i[LANE_W-1:0];
      end else begin
        first_lane_s = first_lane_s;
      end
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      resync_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      resync_cnt_q <= resync_cnt_d;
    end
  end

  // Next-state logic; disable beats a same-cycle retirement while armed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) state_d = ST_ARMED;
        else           state_d = ST_IDLE;
      end
      ST_ARMED: begin
        if (!trace_enabled_i)     state_d = ST_RST;
        else if (valid_i != '0)   state_d = ST_REQ;
        else                      state_d = ST_ARMED;
      end
      ST_REQ: begin
        if (sync_req_ready_i) state_d = ST_RST;
        else                  state_d = ST_REQ;
      end
      ST_RST:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane latch, wait counter, sticky timeout and resync counter updates.
  always_comb begin
    lane_d       = lane_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    resync_cnt_d = resync_cnt_q;

    if ((state_q == ST_ARMED) && trace_enabled_i && (valid_i != '0)) begin
      lane_d = first_lane_s;
    end else begin
      lane_d = lane_q;
    end

    if ((state_q == ST_IDLE) && trigger_s) begin
      wait_cnt_d = '0;
    end else if (in_wait_s && (wait_cnt_q != WAIT_SAT)) begin
      wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // Setting has priority so a timeout cannot be lost to a concurrent clear.
    if (in_wait_s && (wait_cnt_q == MAX_WAIT_M1)) begin
      timeout_d = 1'b1;
    end else if (clear_i) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    if ((state_q == ST_REQ) && sync_req_ready_i) begin
      resync_cnt_d = resync_cnt_q + 16'd1;
    end else begin
      resync_cnt_d = resync_cnt_q;
    end
  end

  // Outputs decoded purely from registers; no input reaches an output.
  always_comb begin
    sync_req_valid_o = (state_q == ST_REQ);
    resync_rst_o     = (state_q == ST_RST);
    sync_pending_o   = (state_q != ST_IDLE);
    sync_req_lane_o  = lane_q;
    wait_cnt_o       = wait_cnt_q;
    timeout_o        = timeout_q;
    resync_cnt_o     = resync_cnt_q;
  end

endmodule

// File: tb/tb_te_resync_controller.sv
// Directed testbench for te_resync_controller (N=2, MAX_WAIT=4).
module tb_te_resync_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trace_enabled_i;
  logic        gt_resync_max_i;
  logic        et_resync_max_i;
  logic [1:0]  valid_i;
  logic        sync_req_valid_o;
  logic [0:0]  sync_req_lane_o;
  logic        sync_req_ready_i;
  logic        resync_rst_o;
  logic        sync_pending_o;
  logic [15:0] wait_cnt_o;
  logic        timeout_o;
  logic        clear_i;
  logic [15:0] resync_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  te_resync_controller #(
    .N        (2),
    .WAIT_W   (16),
    .MAX_WAIT (16'd4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .trace_enabled_i  (trace_enabled_i),
    .gt_resync_max_i  (gt_resync_max_i),
    .et_resync_max_i  (et_resync_max_i),
    .valid_i          (valid_i),
    .sync_req_valid_o (sync_req_valid_o),
    .sync_req_lane_o  (sync_req_lane_o),
    .sync_req_ready_i (sync_req_ready_i),
    .resync_rst_o     (resync_rst_o),
    .sync_pending_o   (sync_pending_o),
    .wait_cnt_o       (wait_cnt_o),
    .timeout_o        (timeout_o),
    .clear_i          (clear_i),
    .resync_cnt_o     (resync_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; trace_enabled_i = 1'b1; gt_resync_max_i = 1'b0;
    et_resync_max_i = 1'b0; valid_i = 2'b00; sync_req_ready_i = 1'b0; clear_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    // Reset state
    check("rst_valid",   32'(sync_req_valid_o), 32'd0);
    check("rst_lane",    32'(sync_req_lane_o),  32'd0);
    check("rst_rstout",  32'(resync_rst_o),     32'd0);
    check("rst_pending", 32'(sync_pending_o),   32'd0);
    check("rst_wait",    32'(wait_cnt_o),       32'd0);
    check("rst_timeout", 32'(timeout_o),        32'd0);
    check("rst_cnt",     32'(resync_cnt_o),     32'd0);

    // Ready without a request has no effect
    sync_req_ready_i = 1'b1;
    step();
    sync_req_ready_i = 1'b0;
    check("idle_ready_rst", 32'(resync_rst_o), 32'd0);
    check("idle_ready_cnt", 32'(resync_cnt_o), 32'd0);

    // Basic minimum-latency path (t0 = this cycle)
    et_resync_max_i = 1'b1;
    step();                                   // t0+1 ARMED
    et_resync_max_i = 1'b0; valid_i = 2'b10;
    check("basic_armed_pend",  32'(sync_pending_o),   32'd1);
    check("basic_armed_valid", 32'(sync_req_valid_o), 32'd0);
    step();                                   // t0+2 REQ
    valid_i = 2'b00; sync_req_ready_i = 1'b1;
    check("basic_req_valid", 32'(sync_req_valid_o), 32'd1);
    check("basic_req_lane",  32'(sync_req_lane_o),  32'd1);
    check("basic_req_rst",   32'(resync_rst_o),     32'd0);
    step();                                   // t0+3 RST
    sync_req_ready_i = 1'b0;
    check("basic_rst_pulse", 32'(resync_rst_o),     32'd1);
    check("basic_rst_valid", 32'(sync_req_valid_o), 32'd0);
    check("basic_cnt",       32'(resync_cnt_o),     32'd1);
    check("basic_wait",      32'(wait_cnt_o),       32'd2);
    step();                                   // t0+4 IDLE
    check("basic_idle_rst",  32'(resync_rst_o),   32'd0);
    check("basic_idle_pend", 32'(sync_pending_o), 32'd0);

    // Backpressure, lowest-lane select, and enable drop ignored in REQ
    gt_resync_max_i = 1'b1;
    step();                                   // ARMED
    gt_resync_max_i = 1'b0; valid_i = 2'b11;
    step();                                   // REQ #1
    valid_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(sync_req_valid_o), 32'd1);
      check("bp_lane",  32'(sync_req_lane_o),  32'd0);
      check("bp_rst",   32'(resync_rst_o),     32'd0);
      if (i == 2) trace_enabled_i = 1'b0;
      step();
    end
    check("bp_valid_last", 32'(sync_req_valid_o), 32'd1);
    sync_req_ready_i = 1'b1;
    step();                                   // RST
    sync_req_ready_i = 1'b0; trace_enabled_i = 1'b1;
    check("bp_rst_pulse", 32'(resync_rst_o), 32'd1);
    check("bp_cnt",       32'(resync_cnt_o), 32'd2);
    check("bp_wait",      32'(wait_cnt_o),   32'd7);
    check("bp_timeout",   32'(timeout_o),    32'd1);
    step();                                   // IDLE
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("bp_clear", 32'(timeout_o), 32'd0);

    // Disable while ARMED, coincident with retirement
    et_resync_max_i = 1'b1;
    step();                                   // ARMED
    et_resync_max_i = 1'b0; trace_enabled_i = 1'b0; valid_i = 2'b11;
    step();                                   // RST
    valid_i = 2'b00; trace_enabled_i = 1'b1;
    check("dis_valid", 32'(sync_req_valid_o), 32'd0);
    check("dis_rst",   32'(resync_rst_o),     32'd1);
    check("dis_cnt",   32'(resync_cnt_o),     32'd2);
    step();                                   // IDLE
    check("dis_idle_rst",  32'(resync_rst_o),   32'd0);
    check("dis_idle_pend", 32'(sync_pending_o), 32'd0);

    // Timeout with no retirement
    et_resync_max_i = 1'b1;
    step();                                   // ARMED cycle 1
    et_resync_max_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_wait",   32'(wait_cnt_o), 32'(i));
      check("to_before", 32'(timeout_o),  32'd0);
      step();
    end
    check("to_set",  32'(timeout_o),  32'd1);
    check("to_wait4", 32'(wait_cnt_o), 32'd4);
    trace_enabled_i = 1'b0;
    step();                                   // RST
    trace_enabled_i = 1'b1;
    check("to_rst_sticky", 32'(timeout_o), 32'd1);
    step();                                   // IDLE
    check("to_idle_sticky", 32'(timeout_o),    32'd1);
    check("to_idle_pend",   32'(sync_pending_o), 32'd0);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("to_clear", 32'(timeout_o), 32'd0);

    // Clear coincident with set: set wins
    et_resync_max_i = 1'b1;
    step();                                   // ARMED wait=0
    et_resync_max_i = 1'b0;
    step(); step(); step();                   // wait=3
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("to_set_wins", 32'(timeout_o), 32'd1);
    trace_enabled_i = 1'b0;
    step();                                   // RST
    trace_enabled_i = 1'b1;
    step();                                   // IDLE

    // Stale threshold flag held through RST
    gt_resync_max_i = 1'b1;
    step();                                   // ARMED
    valid_i = 2'b01;
    step();                                   // REQ
    valid_i = 2'b00; sync_req_ready_i = 1'b1;
    step();                                   // RST, flag still high
    sync_req_ready_i = 1'b0;
    check("stale_rst", 32'(resync_rst_o), 32'd1);
    gt_resync_max_i = 1'b0;
    step();                                   // IDLE
    step();
    check("stale_no_retrig", 32'(sync_pending_o), 32'd0);
    check("stale_cnt",       32'(resync_cnt_o),   32'd3);

    // Reset while in REQ
    et_resync_max_i = 1'b1;
    step();                                   // ARMED
    et_resync_max_i = 1'b0; valid_i = 2'b10;
    step();                                   // REQ
    valid_i = 2'b00;
    check("mid_req_valid", 32'(sync_req_valid_o), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_valid",   32'(sync_req_valid_o), 32'd0);
    check("mid_lane",    32'(sync_req_lane_o),  32'd0);
    check("mid_rst",     32'(resync_rst_o),     32'd0);
    check("mid_pend",    32'(sync_pending_o),   32'd0);
    check("mid_wait",    32'(wait_cnt_o),       32'd0);
    check("mid_timeout", 32'(timeout_o),        32'd0);
    check("mid_cnt",     32'(resync_cnt_o),     32'd0);
    step();
    check("mid_after_rst", 32'(resync_rst_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
